// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoded single-port RAM sitting behind an SPI slave.
// One 10-bit word is accepted per rx_valid rising edge; reads are returned on dout/tx_valid.
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b0,
    parameter int unsigned TX_HOLD   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       addr_err
);

    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [0:0] StTxIdle = 1'b0;
    localparam logic [0:0] StTxHold = 1'b1;

    localparam logic [1:0] CmdWrAddr = 2'b00;
    localparam logic [1:0] CmdWrData = 2'b01;
    localparam logic [1:0] CmdRdAddr = 2'b10;
    localparam logic [1:0] CmdRdData = 2'b11;

    logic [7:0] mem [MEM_DEPTH];

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [0:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           dout_q, dout_d;
    logic                 err_q, err_d;

    logic       accept;
    logic [1:0] cmd;
    logic       wr_in_range, rd_in_range;
    logic       mem_we;
    logic [7:0] rd_data;

    // Post-increment wraps to 0 at MEM_DEPTH; an out-of-range address also lands on 0.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        int unsigned n;
        n = 32'(a) + 32'd1;
        return (n >= MEM_DEPTH) ? '0 : ADDR_SIZE'(n);
    endfunction

    // Reset gates acceptance so nothing is decoded while rst_n is low.
    assign accept      = rst_n & rx_valid & ~rx_valid_q;
    assign cmd         = din[9:8];
    assign wr_in_range = 32'(wr_addr_q) < MEM_DEPTH;
    assign rd_in_range = 32'(rd_addr_q) < MEM_DEPTH;
    assign mem_we      = accept && (cmd == CmdWrData) && wr_in_range;
    assign rd_data     = rd_in_range ? mem[rd_addr_q[IdxW-1:0]] : 8'h00;

    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        err_d     = err_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;

        if (accept) begin
            unique case (cmd)
                CmdWrAddr: wr_addr_d = ADDR_SIZE'(din[7:0]);
                CmdWrData: begin
                    if (!wr_in_range) err_d = 1'b1;
                    if (AUTO_INC) wr_addr_d = next_addr(wr_addr_q);
                end
                CmdRdAddr: rd_addr_d = ADDR_SIZE'(din[7:0]);
                CmdRdData: begin
                    if (!rd_in_range) err_d = 1'b1;
                    if (AUTO_INC) rd_addr_d = next_addr(rd_addr_q);
                end
            endcase
        end

        // Any new word ends the current hold; a read restarts it with fresh data.
        if (accept && (cmd == CmdRdData)) begin
            state_d = StTxHold;
            cnt_d   = 8'(TX_HOLD - 1);
            dout_d  = rd_data;
        end else if (accept) begin
            state_d = StTxIdle;
        end else if (state_q == StTxHold) begin
            if (cnt_q == 8'd0) begin
                state_d = StTxIdle;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            state_q    <= StTxIdle;
            cnt_q      <= 8'd0;
            dout_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr_q[IdxW-1:0]] <= din[7:0];
    end

    assign dout     = dout_q;
    assign tx_valid = (state_q == StTxHold);
    assign addr_err = err_q;

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Single-port synchronous memory with command decoder. Sits directly downstream of the SPI slave: consumes its 10-bit `rx_data`/`rx_valid` words and returns read data on `tx_data`/`tx_valid` for serialisation on MISO. Bits [9:8] of each word select the operation and bits [7:0] carry address or data.

## Interface
Parameters:
- `MEM_DEPTH`, 256: number of 8-bit words; legal range 2..2^ADDR_SIZE.
- `ADDR_SIZE`, 8: address register width, equal to the payload width.
- `AUTO_INC`, 0: when 1, the write and read address registers each post-increment after a data access.
- `TX_HOLD`, 10: number of cycles `tx_valid` stays high per read; legal range 1..255.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  10  command word from the SPI slave (`rx_data`).
- `rx_valid`  in  1  word-valid from the SPI slave. Level signal: high for one or more cycles per word.
- `dout`  out  8  read data to the SPI slave (`tx_data`).
- `tx_valid`  out  1  read data valid to the SPI slave.
- `addr_err`  out  1  sticky flag: an out-of-range address was accessed.

## Operation
- **Accept.** A word is accepted only on a rising edge of `rx_valid`: `rx_valid & ~rx_valid_q`, where `rx_valid_q` is `rx_valid` registered.
  - One accept per high pulse, regardless of pulse length.
  - `rx_valid_q` resets to 0, so `rx_valid` high on the first cycle after reset counts as an edge.
- **Decode** of `din[9:8]` on accept:
  - `00` WR_ADDR: `wr_addr <= din[7:0]`.
  - `01` WR_DATA: `mem[wr_addr] <= din[7:0]`. If AUTO_INC, `wr_addr <= (wr_addr+1) mod MEM_DEPTH`.
  - `10` RD_ADDR: `rd_addr <= din[7:0]`.
  - `11` RD_DATA: start a read of `mem[rd_addr]`; `din[7:0]` is ignored. If AUTO_INC, `rd_addr <= (rd_addr+1) mod MEM_DEPTH`.
- **Out-of-range access.** Any address >= MEM_DEPTH used by WR_DATA or RD_DATA:
  - the write is dropped; a read returns 0x00;
  - `addr_err` is set to 1 and stays set until reset;
  - AUTO_INC wraps such an address to 0.
- **Tx state machine**, states TX_IDLE and TX_HOLD:
  - TX_IDLE -> TX_HOLD on RD_DATA accept. Next cycle: `dout` = read data, `tx_valid` = 1, hold counter = TX_HOLD-1.
  - TX_HOLD: counter decrements each cycle. At 0 -> TX_IDLE, with `tx_valid` = 0 on the following cycle.
  - Any accept while in TX_HOLD drops `tx_valid` the next cycle, so stale data is never shifted into a new transaction.
  - RD_DATA accepted while in TX_HOLD restarts the read: same next-cycle timing, counter reloaded.
  - `dout` keeps its last value when `tx_valid` = 0.
- **Memory.** Contents are not cleared by reset and are preserved across `rst_n`. Power-up contents are undefined.

## Timing
- **Reset values:** `dout` = 0x00, `tx_valid` = 0, `addr_err` = 0, `wr_addr` = `rd_addr` = 0, `rx_valid_q` = 0, state TX_IDLE.
- **Write latency:** data is in memory 1 cycle after the accept edge. A RD_DATA accepted on any later edge returns the new value.
- **Read latency:** accept at cycle N gives `dout`/`tx_valid` at cycle N+1. `tx_valid` is high for cycles N+1..N+TX_HOLD.
- **Address update:** takes effect the cycle after accept. The next accept is at least 2 cycles later, so there is no hazard.
- **Reset mid-read:** `tx_valid` drops on the cycle after `rst_n` is sampled low, and no pending read completes.
- **Accepts during reset:** while `rst_n` = 0 nothing is accepted and `rx_valid_q` is held at 0.

## Test plan
1. **Write then read back.** After reset send 0x000 (WR_ADDR 0x00), 0x1A5, 0x200, 0x300, each as a 3-cycle `rx_valid` pulse.
   -> `dout` = 0xA5 with `tx_valid` = 1 for exactly 10 cycles, starting 1 cycle after the 0x300 edge.
2. **Level vs. edge.** Hold `rx_valid` high for 20 cycles with `din` = 0x1FF after WR_ADDR 0x10.
   -> exactly one write. With AUTO_INC = 1, `wr_addr` = 0x11, not 0x24.
3. **Auto-increment wrap** (AUTO_INC = 1, MEM_DEPTH = 256). WR_ADDR 0xFF, then WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, then RD_DATA twice.
   -> reads return 0x11, then 0x22 from address 0x00.
4. **Out of range** (MEM_DEPTH = 200). WR_ADDR 0xC8, WR_DATA 0x55; RD_ADDR 0xC8, RD_DATA.
   -> `addr_err` = 1 and stays 1; read `dout` = 0x00; memory word 0x00 unchanged.
5. **Accept during hold.** RD_DATA (yields 0x5A), then a WR_ADDR edge 4 cycles later.
   -> `tx_valid` low 1 cycle after that edge. With RD_DATA instead of WR_ADDR, `tx_valid` stays high and is reloaded for a further 10 cycles with the new data.
6. **Reset mid-hold.** Drive `rst_n` = 0 on the 3rd `tx_valid` cycle.
   -> next cycle `tx_valid` = 0, `dout` = 0x00, `addr_err` = 0. After `rst_n` = 1, RD_ADDR to the previously written address, then RD_DATA, still returns the pre-reset memory contents.
